// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bus: decoder control word and operands in, EX copies, stall and stats out.
interface id_ex_stage_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
);
    // ID side
    logic             id_valid;
    logic [1:0]       id_PCSrc;
    logic             id_RegWrite;
    logic [1:0]       id_RegDst;
    logic             id_MemRead;
    logic             id_MemWrite;
    logic [1:0]       id_MemtoReg;
    logic             id_ALUSrc1;
    logic             id_ALUSrc2;
    logic [3:0]       id_ALUOp;
    logic [W-1:0]     id_pc_plus4;
    logic [W-1:0]     id_rs_data;
    logic [W-1:0]     id_rt_data;
    logic [W-1:0]     id_imm_ext;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [4:0]       id_shamt;

    // Pipeline control
    logic             flush;
    logic             ex_hold;
    logic             stall_id;

    // EX side
    logic             ex_valid;
    logic [1:0]       ex_PCSrc;
    logic             ex_RegWrite;
    logic [1:0]       ex_RegDst;
    logic             ex_MemRead;
    logic             ex_MemWrite;
    logic [1:0]       ex_MemtoReg;
    logic             ex_ALUSrc1;
    logic             ex_ALUSrc2;
    logic [3:0]       ex_ALUOp;
    logic [W-1:0]     ex_pc_plus4;
    logic [W-1:0]     ex_rs_data;
    logic [W-1:0]     ex_rt_data;
    logic [W-1:0]     ex_imm_ext;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_shamt;

    // Statistics
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Driver of ID inputs / consumer of EX outputs
    modport master (
        output id_valid, id_PCSrc, id_RegWrite, id_RegDst, id_MemRead, id_MemWrite,
               id_MemtoReg, id_ALUSrc1, id_ALUSrc2, id_ALUOp, id_pc_plus4, id_rs_data,
               id_rt_data, id_imm_ext, id_rs, id_rt, id_rd, id_shamt, flush, ex_hold,
        input  stall_id, ex_valid, ex_PCSrc, ex_RegWrite, ex_RegDst, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_ALUSrc1, ex_ALUSrc2, ex_ALUOp, ex_pc_plus4, ex_rs_data,
               ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd, ex_shamt, bubble_cnt, flush_cnt
    );

    // The pipeline register itself
    modport slave (
        input  id_valid, id_PCSrc, id_RegWrite, id_RegDst, id_MemRead, id_MemWrite,
               id_MemtoReg, id_ALUSrc1, id_ALUSrc2, id_ALUOp, id_pc_plus4, id_rs_data,
               id_rt_data, id_imm_ext, id_rs, id_rt, id_rd, id_shamt, flush, ex_hold,
        output stall_id, ex_valid, ex_PCSrc, ex_RegWrite, ex_RegDst, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_ALUSrc1, ex_ALUSrc2, ex_ALUOp, ex_pc_plus4, ex_rs_data,
               ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd, ex_shamt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch/jump flush and downstream hold with a pending-flush latch.
// Optional: define ID_EX_HAZARD_STATS_EN to build the bubble/flush counters;
// otherwise both counter outputs are tied to zero.
module id_ex_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic         valid;
        logic [1:0]   pc_src;
        logic         reg_write;
        logic [1:0]   reg_dst;
        logic         mem_read;
        logic         mem_write;
        logic [1:0]   mem_to_reg;
        logic         alu_src1;
        logic         alu_src2;
        logic [3:0]   alu_op;
        logic [W-1:0] pc_plus4;
        logic [W-1:0] rs_data;
        logic [W-1:0] rt_data;
        logic [W-1:0] imm_ext;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [4:0]   shamt;
    } ex_word_t;

    ex_word_t ex_q, ex_d, id_word;
    logic     pend_q, pend_d;
    logic     hz;

    // Gather the ID inputs into one word
    always_comb begin
        id_word            = '0;
        id_word.valid      = bus.id_valid;
        id_word.pc_src     = bus.id_PCSrc;
        id_word.reg_write  = bus.id_RegWrite;
        id_word.reg_dst    = bus.id_RegDst;
        id_word.mem_read   = bus.id_MemRead;
        id_word.mem_write  = bus.id_MemWrite;
        id_word.mem_to_reg = bus.id_MemtoReg;
        id_word.alu_src1   = bus.id_ALUSrc1;
        id_word.alu_src2   = bus.id_ALUSrc2;
        id_word.alu_op     = bus.id_ALUOp;
        id_word.pc_plus4   = bus.id_pc_plus4;
        id_word.rs_data    = bus.id_rs_data;
        id_word.rt_data    = bus.id_rt_data;
        id_word.imm_ext    = bus.id_imm_ext;
        id_word.rs         = bus.id_rs;
        id_word.rt         = bus.id_rt;
        id_word.rd         = bus.id_rd;
        id_word.shamt      = bus.id_shamt;
    end

    // Load-use hazard: rt compare is deliberately conservative for every opcode
    always_comb begin
        hz = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & bus.id_valid &
             ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));
    end

    // A flush (live or pending) squashes the dependent instruction, so no stall then
    assign bus.stall_id = bus.ex_hold | (hz & ~bus.flush & ~pend_q);

    // Next EX word and pending-flush flag, highest priority first
    always_comb begin
        ex_d   = ex_q;
        pend_d = pend_q;
        if (bus.ex_hold) begin
            if (bus.flush) pend_d = 1'b1;
        end else if (bus.flush | pend_q) begin
            ex_d   = '0;
            pend_d = 1'b0;
        end else if (hz) begin
            ex_d   = '0;
        end else begin
            ex_d   = id_word;
        end
    end

    // EX pipeline register and pending-flush latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            ex_q   <= ex_d;
            pend_q <= pend_d;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_PCSrc    = ex_q.pc_src;
    assign bus.ex_RegWrite = ex_q.reg_write;
    assign bus.ex_RegDst   = ex_q.reg_dst;
    assign bus.ex_MemRead  = ex_q.mem_read;
    assign bus.ex_MemWrite = ex_q.mem_write;
    assign bus.ex_MemtoReg = ex_q.mem_to_reg;
    assign bus.ex_ALUSrc1  = ex_q.alu_src1;
    assign bus.ex_ALUSrc2  = ex_q.alu_src2;
    assign bus.ex_ALUOp    = ex_q.alu_op;
    assign bus.ex_pc_plus4 = ex_q.pc_plus4;
    assign bus.ex_rs_data  = ex_q.rs_data;
    assign bus.ex_rt_data  = ex_q.rt_data;
    assign bus.ex_imm_ext  = ex_q.imm_ext;
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_shamt    = ex_q.shamt;

`ifdef ID_EX_HAZARD_STATS_EN
    logic [CNT_W-1:0] bubble_q, flush_q;
    logic             bubble_inc, flush_inc;

    // Which kind of bubble, if any, this edge inserts
    always_comb begin
        flush_inc  = ~bus.ex_hold & (bus.flush | pend_q);
        bubble_inc = ~bus.ex_hold & ~(bus.flush | pend_q) & hz;
    end

    // Saturating hazard statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (bubble_inc && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
            if (flush_inc && (flush_q != '1))   flush_q  <= flush_q + CNT_W'(1);
        end
    end

    assign bus.bubble_cnt = bubble_q;
    assign bus.flush_cnt  = flush_q;
`else
    assign bus.bubble_cnt = '0;
    assign bus.flush_cnt  = '0;
`endif
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the five-stage pipelined CPU. It sits directly downstream of the instruction decoder and register file read. Each cycle it captures the decoded control word and operand data into the EX stage. It also owns load-use hazard detection, bubble insertion, branch/jump flush, and downstream hold with a pending-flush latch.

## Interface
- `W`, default 32, datapath width.
- `CNT_W`, default 16, width of hazard statistics counters.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_PCSrc` in 2; `id_RegWrite` in 1; `id_RegDst` in 2; `id_MemRead` in 1; `id_MemWrite` in 1; `id_MemtoReg` in 2; `id_ALUSrc1` in 1; `id_ALUSrc2` in 1; `id_ALUOp` in 4: decoder control word.
- `id_pc_plus4`, `id_rs_data`, `id_rt_data`, `id_imm_ext`  in  W each  operands; immediate already extended/lui-shifted in ID.
- `id_rs`, `id_rt`, `id_rd`, `id_shamt`  in  5 each  instruction fields.
- `flush`  in  1  branch/jump redirect resolved in ID; squash the instruction entering EX.
- `ex_hold`  in  1  downstream (multi-cycle mul, memory) cannot accept; freeze EX.
- `stall_id`  out  1  hold PC and IF/ID this cycle (combinational).
- `ex_valid`, `ex_*`  out  same widths as the `id_*` inputs  registered EX copies.
- `bubble_cnt`, `flush_cnt`  out  CNT_W each  statistics.

## Operation
- Load-use hazard, combinational: `hz = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt))`. The rt comparison is conservative and applies to every opcode.
- `stall_id = ex_hold | (hz & ~flush & ~pend_flush)`.
- Register update per edge, highest priority first:
  - reset: all `ex_*` = 0, `ex_valid` = 0, `pend_flush` = 0, counters = 0.
  - `ex_hold`: EX registers unchanged. If `flush` = 1, set `pend_flush`.
  - `flush | pend_flush`: load a bubble, clear `pend_flush`, increment `flush_cnt`.
  - `hz`: load a bubble, increment `bubble_cnt`.
  - otherwise: load all `id_*` inputs, with `ex_valid = id_valid`.
- Bubble: every `ex_*` output and `ex_valid` are 0. A bubble is therefore a no-op, since RegWrite, MemRead, MemWrite and PCSrc are all 0.
- Counters saturate at all-ones and do not wrap.

## Timing
- Latency: one cycle, ID inputs to EX outputs.
- `stall_id` is combinational from the EX registers and the ID inputs. Same-cycle use is required by PC/IF-ID enables.
- A load-use stall lasts exactly one cycle. The bubble clears `ex_MemRead`, so `hz` drops on the next cycle.
- flush + hz in the same cycle: flush wins and no stall is raised. The dependent instruction is squashed anyway.
- flush during `ex_hold`: recorded in `pend_flush`. The first non-hold edge inserts the bubble. A second flush while pending does not raise the count twice.
- `reset` mid-hold or mid-pending: all state clears immediately. The first edge after deassertion behaves as normal load.
- `ex_rt == 0` never stalls.

## Configuration
- `ID_EX_HAZARD_STATS_EN` defined: `bubble_cnt` and `flush_cnt` are implemented as specified.
- `ID_EX_HAZARD_STATS_EN` undefined: no counter flops are built and both outputs are tied to 0. Pipeline behaviour is identical either way.

## Test plan
- Straight-line: ID presents an addi with RegWrite=1, ALUSrc2=1, ALUOp=0, imm=0x0000_0005. The next edge gives those exact EX values with `ex_valid`=1 and `stall_id`=0.
- Load-use: EX holds lw with rt=8 and the next ID has rs=8. Required: `stall_id`=1 for one cycle, then an EX bubble (all 0), then the held ID instruction loads. `bubble_cnt` is 1.
- Load with rt=0 followed by a use of $0: `stall_id`=0 and no bubble.
- Flush with a simultaneous hazard: `stall_id`=0, the next EX is a bubble, `flush_cnt`=1, `bubble_cnt` is unchanged.
- Hold with flush: `ex_hold`=1 for 3 cycles with `flush` pulsed in cycle 1.
  - EX stays frozen for all 3 cycles.
  - A bubble loads on the first edge after `ex_hold` drops.
  - `flush_cnt` is 1.
- Async reset mid-hold with `pend_flush`=1: outputs go to 0 before the next edge. After release, a normal load occurs with no extra bubble.
